// File: rtl/regfile_pkg.sv
// regfile_pkg: byte-lane width and clear-FSM state type shared by the register file
package regfile_pkg;
  localparam int BYTE_W = 8;
  typedef enum logic {IDLE, CLEAR} clr_state_t;
endpackage

// File: rtl/regfile_2r1w_if.sv
// regfile_2r1w_if: write port, read ports A/B, clear handshake; master issues requests, slave returns rd_data/rd_valid/busy/err
interface regfile_2r1w_if
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
);
  logic wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH/BYTE_W-1:0] wr_be;
  logic rd_en_a, rd_en_b;
  logic [ADDR_WIDTH-1:0] rd_addr_a, rd_addr_b;
  logic [DATA_WIDTH-1:0] rd_data_a, rd_data_b;
  logic rd_valid_a, rd_valid_b;
  logic clr_req, busy, err;
  modport master(
    output wr_en, wr_addr, wr_data, wr_be, rd_en_a, rd_en_b, rd_addr_a, rd_addr_b, clr_req,
    input rd_data_a, rd_data_b, rd_valid_a, rd_valid_b, busy, err
  );
  modport slave(
    input wr_en, wr_addr, wr_data, wr_be, rd_en_a, rd_en_b, rd_addr_a, rd_addr_b, clr_req,
    output rd_data_a, rd_data_b, rd_valid_a, rd_valid_b, busy, err
  );
endinterface

// File: rtl/regfile_clear_fsm.sv
// regfile_clear_fsm: zeroes one entry per cycle after clr_req; in clk/rst/clr_req, out busy and clr_addr (entry to zero)
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_req,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] clr_addr
);
  clr_state_t state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;
  logic last;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  always_comb begin
    last      = cnt == ADDR_WIDTH'(DEPTH - 1);
    state_nxt = state == IDLE ? (clr_req ? CLEAR : IDLE) : (last ? IDLE : CLEAR);
    cnt_nxt   = state == CLEAR && !last ? cnt + 1'b1 : '0;
  end
  assign busy     = state == CLEAR;
  assign clr_addr = cnt;
endmodule

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: byte-masked 2-read/1-write register file with write-first bypass and clear; ports clk, rst, bus (slave)
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input logic           clk,
  input logic           rst,
  regfile_2r1w_if.slave bus
);
  localparam int NB = DATA_WIDTH / BYTE_W;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic busy, wr_ok, ok_a, ok_b, wr_go, acc_a, acc_b;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic [DATA_WIDTH-1:0] wr_merged, data_a, data_b;
  function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] old, nd, input logic [NB-1:0] be);
    merge = old;
    for (int i = 0; i < NB; i++)
      if (be[i]) merge[i*BYTE_W +: BYTE_W] = nd[i*BYTE_W +: BYTE_W];
  endfunction
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return 32'(a) < DEPTH;
  endfunction
  regfile_clear_fsm #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_clr (
    .clk, .rst, .clr_req(bus.clr_req), .busy, .clr_addr
  );
  assign bus.busy = busy;
  always_comb begin
    wr_ok     = in_range(bus.wr_addr);
    ok_a      = in_range(bus.rd_addr_a);
    ok_b      = in_range(bus.rd_addr_b);
    wr_go     = bus.wr_en && !busy && wr_ok;
    acc_a     = bus.rd_en_a && !busy;
    acc_b     = bus.rd_en_b && !busy;
    wr_merged = merge(mem[bus.wr_addr], bus.wr_data, bus.wr_be);
    data_a    = !ok_a ? '0 : wr_go && bus.wr_addr == bus.rd_addr_a ? wr_merged : mem[bus.rd_addr_a];
    data_b    = !ok_b ? '0 : wr_go && bus.wr_addr == bus.rd_addr_b ? wr_merged : mem[bus.rd_addr_b];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      bus.rd_data_a  <= '0;
      bus.rd_data_b  <= '0;
      bus.rd_valid_a <= 1'b0;
      bus.rd_valid_b <= 1'b0;
      bus.err        <= 1'b0;
    end else begin
      if (busy) mem[clr_addr] <= '0;
      else if (wr_go) mem[bus.wr_addr] <= wr_merged;
      bus.rd_valid_a <= acc_a;
      bus.rd_valid_b <= acc_b;
      bus.rd_data_a  <= acc_a ? data_a : '0;
      bus.rd_data_b  <= acc_b ? data_b : '0;
      bus.err        <= !busy && (bus.wr_en && !wr_ok || bus.rd_en_a && !ok_a || bus.rd_en_b && !ok_b);
    end
endmodule

// File: doc/regfile_2r1w.md
REGFILE_2R1W -- requirements
Module: regfile_2r1w

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, entry width in bits; multiple of 8.
REQ-002 SHALL have parameter DEPTH, default 16, number of entries; 2..256, not necessarily a power of 2.
REQ-003 SHALL have parameter ADDR_WIDTH, default 4, address width; ceil(log2(DEPTH)).
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port wr_en  input  1  write request.
REQ-007 SHALL have port wr_addr  input  ADDR_WIDTH  write address.
REQ-008 SHALL have port wr_data  input  DATA_WIDTH  write data.
REQ-009 SHALL have port wr_be  input  DATA_WIDTH/8  byte enables, bit i covers wr_data[8i+7:8i].
REQ-010 SHALL have ports rd_en_a / rd_en_b  input  1  read requests, ports A and B.
REQ-011 SHALL have ports rd_addr_a / rd_addr_b  input  ADDR_WIDTH  read addresses.
REQ-012 SHALL have ports rd_data_a / rd_data_b  output  DATA_WIDTH  registered read data.
REQ-013 SHALL have ports rd_valid_a / rd_valid_b  output  1  read data valid, one-cycle pulse per accepted read.
REQ-014 SHALL have port clr_req  input  1  request to zero all entries.
REQ-015 SHALL have port busy  output  1  clear sequence in progress.
REQ-016 SHALL have port err  output  1  one-cycle pulse on any out-of-range access.

Function
REQ-017 Write SHALL update, on the clk edge with wr_en=1, only bytes of entry wr_addr whose wr_be bit is 1; wr_be=0 writes nothing.
REQ-018 Read latency SHALL be 1 cycle: rd_en_x=1 at edge N gives rd_data_x and rd_valid_x=1 after edge N, held until edge N+1.
REQ-019 Cycles with no accepted read on a port SHALL drive that port rd_data=0, rd_valid=0.
REQ-020 Same-cycle write and read to the same in-range address SHALL return write-first data: enabled bytes from wr_data, remaining bytes from stored entry.
REQ-021 Ports A and B SHALL be independent; both may read the same address in one cycle and both return identical data.
REQ-022 Address >= DEPTH SHALL: ignore the write, return rd_data=0 with rd_valid=1 on that read port, and pulse err for one cycle (single pulse if several out-of-range accesses coincide).
REQ-023 Clear FSM SHALL have states IDLE and CLEAR; IDLE->CLEAR on clr_req=1; counter zeroes entry 0..DEPTH-1, one per cycle; CLEAR->IDLE after entry DEPTH-1.
REQ-024 busy SHALL be 1 for exactly DEPTH cycles, starting the cycle after clr_req is sampled.
REQ-025 While busy=1: wr_en and rd_en_x SHALL be ignored (no write, rd_valid=0, rd_data=0, no err); clr_req SHALL be ignored.
REQ-026 clr_req together with wr_en/rd_en in IDLE SHALL complete those accesses that cycle, then start clearing.

Reset
REQ-027 rst=1 SHALL immediately zero all entries, rd_data_a/b, rd_valid_a/b, err, busy, clear counter, and force IDLE, independent of clk.
REQ-028 rst asserted mid-clear SHALL abort the sequence; after release the block is in IDLE with all entries zero.
REQ-029 First access SHALL be accepted on the first rising clk edge after rst deasserts.

Structure
REQ-030 Package regfile_pkg SHALL hold the clear-FSM state type (IDLE, CLEAR) and the byte-lane width constant (8).
REQ-031 Clear sequencer (FSM, counter, busy) SHALL be sub-module regfile_clear_fsm; storage, write masking, bypass and read ports stay in regfile_2r1w.

Verification
REQ-032 Reset then read A addr 3 -> rd_data_a=0x0000, rd_valid_a=1 one cycle later.
REQ-033 Write addr 5 0xABCD be=11, then write addr 5 0x1234 be=01, read A addr 5 -> 0xAB34.
REQ-034 Same cycle: write addr 2 0x5A5A be=10 (stored 0x1111), read A and B addr 2 -> both 0x5A11 next cycle.
REQ-035 DEPTH=12: write addr 13, read B addr 14 -> err pulses once, rd_data_b=0, rd_valid_b=1, no entry modified.
REQ-036 Fill all 16 entries with 0xFFFF, pulse clr_req -> busy high 16 cycles, reads ignored during busy, all entries read 0 afterwards.
REQ-037 Assert rst at clear cycle 7 -> busy=0 immediately, state IDLE, all entries read 0 after release.
